mem_march_ctrl: RTL and testbench
=================================

Name: mem_march_ctrl

Overview:
- Test-controller master for the ram4096X16 single-port RAM. It drives the RAM's addr, rw and bidirectional data bus: it writes two address-derived patterns, reads each one back and compares the result.
- It sits between the system (start/status) and the RAM port. It replaces hand-sequenced stimulus so memory can be checked in-system.

Parameters:
- N_WORDS, 4096: words tested. Must be a power of two, a multiple of 4 and at most 4096.
- RD_LAT, 1: clock edges from the read-address cycle to the edge where the controller samples mem_data. Legal values are 1..2.

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse that begins a run; ignored while busy=1
- mem_addr  out  12  RAM address
- mem_rw  out  1  1 = write, 0 = read
- mem_data  inout  16  RAM data bus; driven only while mem_rw=1, otherwise high-Z
- busy  out  1  run in progress
- done  out  1  run finished; sticky until the next accepted start or reset
- pass  out  1  valid when done=1; 1 = zero mismatches
- err_cnt  out  16  number of mismatches, saturating at 0xFFFF
- first_err_addr  out  12  address of the first mismatch
- first_err_data  out  16  data read at the first mismatch

Behaviour:
- Reset (rst_n=0 at a posedge) places these values on the outputs:
  - state IDLE
  - mem_rw=0, mem_addr=0, mem_data high-Z
  - busy=0, done=0, pass=0
  - err_cnt=0, first_err_addr=0, first_err_data=0
  - the read pipeline is flushed
- Reset mid-run: the same values apply at the next edge. The run is abandoned and no partial status is kept.
- Address order:
  - Counter cnt runs 0..N_WORDS-1.
  - mem_addr = {cnt[1:0], cnt>>2 zero-extended to 10 bits}, i.e. interleaved across the four 1K banks: 0x000, 0x400, 0x800, 0xC00, 0x001, ...
- Patterns for address A:
  - P0 = {4'h0, A}.
  - P1 = {A[7:0], 4'h0, A[11:10], 2'b00}.
- States: IDLE, WR0, RD0, DR0, WR1, RD1, DR1, DONE.
  - IDLE/DONE, start=1: go to WR0 at the next edge; cnt=0, busy=1, done=0, pass=0, err_cnt and first_err_* cleared.
  - WRx: one word per cycle, with mem_rw=1, mem_data=Px(mem_addr) and the bus driven. After cnt=N_WORDS-1, go to RDx with cnt=0.
  - RDx: one read per cycle, with mem_rw=0 and the bus released in the same cycle mem_rw falls. After cnt=N_WORDS-1, go to DRx.
  - DRx: lasts RD_LAT cycles with mem_rw=0 and no new reads. DR0 then goes to WR1; DR1 then goes to DONE.
  - DONE: busy=0, done=1, pass=(err_cnt==0). The outputs hold until start or reset.
- Total busy duration: 4*N_WORDS + 2*RD_LAT cycles.
- Read pipeline:
  - Each read issue pushes {valid, addr, expected Px} into an RD_LAT-deep shift register.
  - When a valid entry exits, mem_data is sampled at that edge and compared with the expected value.
  - Pattern-0 reads are compared against P0 and pattern-1 reads against P1.
- On mismatch:
  - err_cnt increments, saturating.
  - If err_cnt was 0, first_err_addr and first_err_data are captured.
  - A sampled X or Z bit counts as a mismatch.
- Bus discipline:
  - The controller never drives mem_data while mem_rw=0.
  - There is no cycle with mem_rw=1 and the bus released.
  - On a write-to-read switch (WRx to RDx), the first read address follows the last write by exactly one cycle.
- start during busy has no effect. start in the same cycle as rst_n=0 is ignored.

Test Plan:
- Bench setup: behavioural ram4096X16 modelled with RD_LAT=1.
- Nominal run (N_WORDS=4096, RD_LAT=1): start pulse -> first WR0 cycles are addr/data 0x000/0x0000, 0x400/0x0400, 0x800/0x0800, 0xC00/0x0C00, 0x001/0x0001. done rises 16386 cycles after busy rises; pass=1, err_cnt=0.
- Pattern 1 check: in WR1 at cnt=5 -> mem_addr=0x401, mem_data=0x0104. At cnt=14 -> mem_addr=0x803, mem_data=0x0308.
- Injected fault: the RAM model clears data bit 3 on reads of 0x802 ->
  - RD0 sees 0x0802 (correct).
  - RD1 expects 0x0208 and reads 0x0200.
  - Final state: err_cnt=1, first_err_addr=0x802, first_err_data=0x0200, pass=0.
- Start handling: a second start pulse mid-RD0 -> ignored, with busy continuous and total length unchanged. start after done -> err_cnt cleared, done=0 on the next edge, and a new run begins.
- Reset mid-operation: rst_n=0 for one cycle during RD1 -> next edge busy=0, mem_rw=0, bus Z, err_cnt=0. A following start completes normally with pass=1.
- Bus contention and short run:
  - Bus check: monitor over the whole nominal run -> mem_data never X. The controller drive is never active while mem_rw=0.
  - Short run (N_WORDS=16, RD_LAT=2): run completes in 68 busy cycles with pass=1.

Source files
------------

// File: rtl/mem_march_ctrl.sv
// March-style self-test master for a ram4096X16 port: writes two address-derived
// patterns, reads each back through an RD_LAT-deep compare pipeline, reports status.
module mem_march_ctrl #(
    parameter int unsigned N_WORDS = 4096,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [11:0] mem_addr,
    output logic        mem_rw,
    inout  wire  [15:0] mem_data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [11:0] first_err_addr,
    output logic [15:0] first_err_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR0, S_RD0, S_DR0, S_WR1, S_RD1, S_DR1, S_DONE
    } state_t;

    state_t                   r_state;
    logic [11:0]              r_cnt;
    logic                     r_rw;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_pass;
    logic [15:0]              r_err;
    logic [11:0]              r_fea;
    logic [15:0]              r_fed;
    logic [RD_LAT-1:0]        r_pv;
    logic [RD_LAT-1:0][11:0]  r_pa;
    logic [RD_LAT-1:0][15:0]  r_pe;

    logic                     w_p1;
    logic                     w_rd;
    logic                     w_last;
    logic                     w_dlast;
    logic                     w_chk;
    logic                     w_mis;
    logic [15:0]              w_pat;
    logic [15:0]              w_err_nxt;

    // Bank-interleaved order: low two counter bits select the 1K bank.
    assign mem_addr = {r_cnt[1:0], r_cnt[11:2]};
    assign w_p1     = (r_state == S_WR1) || (r_state == S_RD1);
    assign w_pat    = w_p1 ? {mem_addr[7:0], 4'h0, mem_addr[11:10], 2'b00}
                           : {4'h0, mem_addr};
    assign mem_rw   = r_rw;
    assign mem_data = r_rw ? w_pat : 'z;

    assign w_rd    = (r_state == S_RD0) || (r_state == S_RD1);
    assign w_last  = (r_cnt == 12'(N_WORDS - 1));
    assign w_dlast = (r_cnt == 12'(RD_LAT - 1));
    assign w_chk   = r_pv[RD_LAT-1];

    // Equality failing on X/Z bits leaves the default, so unknowns count as errors.
    always_comb begin
        w_mis = 1'b1;
        if (mem_data == r_pe[RD_LAT-1]) w_mis = 1'b0;
    end

    assign w_err_nxt = (w_chk && w_mis && (r_err != '1)) ? r_err + 16'd1 : r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rw    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fea   <= '0;
            r_fed   <= '0;
            r_pv    <= '0;
            r_pa    <= '0;
            r_pe    <= '0;
        end else begin
            r_pv[0] <= w_rd;
            r_pa[0] <= mem_addr;
            r_pe[0] <= w_pat;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pe[i] <= r_pe[i-1];
            end

            if (w_chk && w_mis && (r_err == '0)) begin
                r_fea <= r_pa[RD_LAT-1];
                r_fed <= mem_data;
            end
            r_err <= w_err_nxt;

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_WR0;
                        r_cnt   <= '0;
                        r_rw    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_err   <= '0;
                        r_fea   <= '0;
                        r_fed   <= '0;
                    end
                end
                S_WR0, S_WR1: begin
                    r_cnt <= r_cnt + 12'd1;
                    if (w_last) begin
                        r_state <= (r_state == S_WR0) ? S_RD0 : S_RD1;
                        r_cnt   <= '0;
                        r_rw    <= 1'b0;
                    end
                end
                S_RD0, S_RD1: begin
                    r_cnt <= r_cnt + 12'd1;
                    if (w_last) begin
                        r_state <= (r_state == S_RD0) ? S_DR0 : S_DR1;
                        r_cnt   <= '0;
                    end
                end
                S_DR0: begin
                    r_cnt <= r_cnt + 12'd1;
                    if (w_dlast) begin
                        r_state <= S_WR1;
                        r_cnt   <= '0;
                        r_rw    <= 1'b1;
                    end
                end
                S_DR1: begin
                    r_cnt <= r_cnt + 12'd1;
                    if (w_dlast) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_nxt == '0);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_cnt        = r_err;
    assign first_err_addr = r_fea;
    assign first_err_data = r_fed;

endmodule

// File: tb/tb_mem_march_ctrl.sv
// Bench for mem_march_ctrl: behavioural RAMs (latency 1 and 2), directed scenarios,
// and a per-cycle bus monitor keyed on the cycle index since busy rose.
module tb_mem_march_ctrl;

    localparam int unsigned NW0 = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        fault_en = 1'b0;

    logic [11:0] mem_addr0, mem_addr1;
    logic        mem_rw0, mem_rw1;
    wire  [15:0] mem_data0, mem_data1;
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] err0, err1, fed0, fed1;
    logic [11:0] fea0, fea1;

    int n_cmp = 0;
    int n_bad = 0;

    mem_march_ctrl #(.N_WORDS(4096), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .mem_addr(mem_addr0), .mem_rw(mem_rw0), .mem_data(mem_data0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .first_err_addr(fea0), .first_err_data(fed0)
    );

    mem_march_ctrl #(.N_WORDS(16), .RD_LAT(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .mem_addr(mem_addr1), .mem_rw(mem_rw1), .mem_data(mem_data1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_err_addr(fea1), .first_err_data(fed1)
    );

    // RAM with one-cycle read latency; optional stuck-low bit 3 on reads of 0x802.
    logic [15:0] mem0 [4096];
    logic [15:0] rdata0 = '0;
    always @(posedge clk) begin
        if (mem_rw0) mem0[mem_addr0] <= mem_data0;
        else rdata0 <= (fault_en && mem_addr0 == 12'h802) ? (mem0[mem_addr0] & 16'hFFF7)
                                                          : mem0[mem_addr0];
    end
    assign mem_data0 = mem_rw0 ? 'z : rdata0;

    logic [15:0] mem1 [4096];
    logic [15:0] rdata1a = '0;
    logic [15:0] rdata1b = '0;
    always @(posedge clk) begin
        if (mem_rw1) mem1[mem_addr1] <= mem_data1;
        else rdata1a <= mem1[mem_addr1];
        rdata1b <= rdata1a;
    end
    assign mem_data1 = mem_rw1 ? 'z : rdata1b;

    function automatic logic [15:0] pat(input bit p1, input logic [11:0] a);
        return p1 ? {a[7:0], 4'h0, a[11:10], 2'b00} : {4'h0, a};
    endfunction

    // Expected bus behaviour at busy-cycle index k of a 4096-word, latency-1 run.
    function automatic bit bus_ok(input int unsigned k, input logic rw, input logic [11:0] a,
                                  input logic [15:0] d, input logic [15:0] rd);
        int unsigned c;
        bit ewr, p1, dr;
        logic [11:0] ea;
        c = 0; ewr = 0; p1 = 0; dr = 0;
        if (k < NW0) begin ewr = 1; c = k; end
        else if (k < 2*NW0) c = k - NW0;
        else if (k == 2*NW0) dr = 1;
        else if (k < 3*NW0 + 1) begin ewr = 1; p1 = 1; c = k - 2*NW0 - 1; end
        else if (k < 4*NW0 + 1) begin p1 = 1; c = k - 3*NW0 - 1; end
        else dr = 1;
        ea = {c[1:0], c[11:2]};
        if (rw !== ewr) return 0;
        if (!dr && a !== ea) return 0;
        if (ewr) return d === pat(p1, ea);
        return d === rd;
    endfunction

    int unsigned bcyc = 0;
    int bus_bad = 0;
    always @(negedge clk) begin
        if (busy0) begin
            if (!bus_ok(bcyc, mem_rw0, mem_addr0, mem_data0, rdata0)) bus_bad <= bus_bad + 1;
            bcyc <= bcyc + 1;
        end else begin
            bcyc <= 0;
        end
    end

    logic [11:0] sa [7];
    logic [15:0] sd [7];
    logic        s_done, s_busy;
    logic [15:0] s_err;
    logic [11:0] s_fea;

    // Starts a run on u_dut0 and counts busy cycles; optionally pulses start or reset mid-run.
    task automatic run0(input int mid_at, input int rst_at, output int ncyc);
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        ncyc = 0;
        s_done = done0; s_busy = busy0; s_err = err0; s_fea = fea0;
        while (busy0 && ncyc < 20000) begin
            if (ncyc < 5) begin sa[ncyc] = mem_addr0; sd[ncyc] = mem_data0; end
            if (ncyc == 8198) begin sa[5] = mem_addr0; sd[5] = mem_data0; end
            if (ncyc == 8207) begin sa[6] = mem_addr0; sd[6] = mem_data0; end
            start0 = (ncyc == mid_at);
            rst_n  = !(ncyc == rst_at);
            ncyc++;
            @(negedge clk);
        end
        start0 = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start0 = 1'b1; start1 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; start0 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0h want 0", busy0); end
        n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL reset_done got %0h want 0", done0); end
        n_cmp++; if (pass0 !== 1'b0) begin n_bad++; $display("FAIL reset_pass got %0h want 0", pass0); end
        n_cmp++; if (err0 !== 16'h0) begin n_bad++; $display("FAIL reset_err got %0h want 0", err0); end
        n_cmp++; if (fea0 !== 12'h0) begin n_bad++; $display("FAIL reset_fea got %0h want 0", fea0); end
        n_cmp++; if (fed0 !== 16'h0) begin n_bad++; $display("FAIL reset_fed got %0h want 0", fed0); end
        n_cmp++; if (mem_rw0 !== 1'b0) begin n_bad++; $display("FAIL reset_rw got %0h want 0", mem_rw0); end
        n_cmp++; if (mem_addr0 !== 12'h0) begin n_bad++; $display("FAIL reset_addr got %0h want 0", mem_addr0); end
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_start_ignored got %0h want 0", busy1); end
    endtask

    task automatic test_fault_and_busy_start;
        int n;
        fault_en = 1'b1;
        run0(5000, -1, n);
        fault_en = 1'b0;
        n_cmp++; if (n != 16386) begin n_bad++; $display("FAIL fault_len got %0d want 16386", n); end
        n_cmp++; if (done0 !== 1'b1) begin n_bad++; $display("FAIL fault_done got %0h want 1", done0); end
        n_cmp++; if (pass0 !== 1'b0) begin n_bad++; $display("FAIL fault_pass got %0h want 0", pass0); end
        n_cmp++; if (err0 !== 16'h1) begin n_bad++; $display("FAIL fault_err got %0h want 1", err0); end
        n_cmp++; if (fea0 !== 12'h802) begin n_bad++; $display("FAIL fault_addr got %0h want 802", fea0); end
        n_cmp++; if (fed0 !== 16'h0200) begin n_bad++; $display("FAIL fault_data got %0h want 0200", fed0); end
    endtask

    task automatic test_restart_reset_mid;
        int n;
        fault_en = 1'b1;
        run0(-1, 12400, n);
        fault_en = 1'b0;
        n_cmp++; if (s_done !== 1'b0) begin n_bad++; $display("FAIL restart_done got %0h want 0", s_done); end
        n_cmp++; if (s_busy !== 1'b1) begin n_bad++; $display("FAIL restart_busy got %0h want 1", s_busy); end
        n_cmp++; if (s_err !== 16'h0) begin n_bad++; $display("FAIL restart_err got %0h want 0", s_err); end
        n_cmp++; if (s_fea !== 12'h0) begin n_bad++; $display("FAIL restart_fea got %0h want 0", s_fea); end
        n_cmp++; if (n != 12401) begin n_bad++; $display("FAIL rstmid_len got %0d want 12401", n); end
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %0h want 0", busy0); end
        n_cmp++; if (mem_rw0 !== 1'b0) begin n_bad++; $display("FAIL rstmid_rw got %0h want 0", mem_rw0); end
        n_cmp++; if (err0 !== 16'h0) begin n_bad++; $display("FAIL rstmid_err got %0h want 0", err0); end
        n_cmp++; if (done0 !== 1'b0) begin n_bad++; $display("FAIL rstmid_done got %0h want 0", done0); end
        n_cmp++; if (mem_data0 !== rdata0) begin n_bad++; $display("FAIL rstmid_bus got %0h want %0h", mem_data0, rdata0); end
    endtask

    task automatic test_nominal;
        int n;
        logic [11:0] ea [5];
        ea[0] = 12'h000; ea[1] = 12'h400; ea[2] = 12'h800; ea[3] = 12'hC00; ea[4] = 12'h001;
        run0(-1, -1, n);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (sa[i] !== ea[i]) begin n_bad++; $display("FAIL wr0_addr[%0d] got %0h want %0h", i, sa[i], ea[i]); end
            n_cmp++; if (sd[i] !== {4'h0, ea[i]}) begin n_bad++; $display("FAIL wr0_data[%0d] got %0h want %0h", i, sd[i], {4'h0, ea[i]}); end
        end
        n_cmp++; if (n != 16386) begin n_bad++; $display("FAIL nom_len got %0d want 16386", n); end
        n_cmp++; if (done0 !== 1'b1) begin n_bad++; $display("FAIL nom_done got %0h want 1", done0); end
        n_cmp++; if (pass0 !== 1'b1) begin n_bad++; $display("FAIL nom_pass got %0h want 1", pass0); end
        n_cmp++; if (err0 !== 16'h0) begin n_bad++; $display("FAIL nom_err got %0h want 0", err0); end
    endtask

    task automatic test_pattern1;
        n_cmp++; if (sa[5] !== 12'h401) begin n_bad++; $display("FAIL p1_addr5 got %0h want 401", sa[5]); end
        n_cmp++; if (sd[5] !== 16'h0104) begin n_bad++; $display("FAIL p1_data5 got %0h want 0104", sd[5]); end
        n_cmp++; if (sa[6] !== 12'h803) begin n_bad++; $display("FAIL p1_addr14 got %0h want 803", sa[6]); end
        n_cmp++; if (sd[6] !== 16'h0308) begin n_bad++; $display("FAIL p1_data14 got %0h want 0308", sd[6]); end
    endtask

    task automatic test_bus;
        n_cmp++; if (bus_bad != 0) begin n_bad++; $display("FAIL bus_monitor got %0d bad cycles want 0", bus_bad); end
    endtask

    task automatic test_short;
        int n;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        n = 0;
        while (busy1 && n < 500) begin n++; @(negedge clk); end
        n_cmp++; if (n != 68) begin n_bad++; $display("FAIL short_len got %0d want 68", n); end
        n_cmp++; if (done1 !== 1'b1) begin n_bad++; $display("FAIL short_done got %0h want 1", done1); end
        n_cmp++; if (pass1 !== 1'b1) begin n_bad++; $display("FAIL short_pass got %0h want 1", pass1); end
        n_cmp++; if (err1 !== 16'h0) begin n_bad++; $display("FAIL short_err got %0h want 0", err1); end
    endtask

    initial begin
        test_reset();
        test_fault_and_busy_start();
        test_restart_reset_mid();
        test_nominal();
        test_pattern1();
        test_bus();
        test_short();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
